// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch sequencing controller: opcode IDs of the
// branch-class instructions, controller state encoding, default shadow length
// and small decode helpers.
package branch_ctrl_pkg;

    // Instruction IDs of the branch-class instructions, as issued by decode.
    localparam logic [6:0] ID_BR    = 7'h40;
    localparam logic [6:0] ID_BRA   = 7'h41;
    localparam logic [6:0] ID_BRSL  = 7'h42;
    localparam logic [6:0] ID_BRASL = 7'h43;
    localparam logic [6:0] ID_BRZ   = 7'h44;
    localparam logic [6:0] ID_BRNZ  = 7'h45;
    localparam logic [6:0] ID_BRHZ  = 7'h46;
    localparam logic [6:0] ID_BRHNZ = 7'h47;

    // Number of refill cycles after the flush cycle in which branches are squashed.
    localparam int BC_SHADOW_DEFAULT = 2;

    // Width of the refill down-counter; holds SHADOW-1 for SHADOW up to 15.
    localparam int BC_REFILL_W = 4;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } bc_state_e;

    // True when the ID names one of the eight branch-class instructions.
    function automatic logic is_branch_id(input logic [6:0] id);
        logic r;
        case (id)
            ID_BR, ID_BRA, ID_BRSL, ID_BRASL,
            ID_BRZ, ID_BRNZ, ID_BRHZ, ID_BRHNZ: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True when the ID names a branch that writes a link register.
    function automatic logic is_link_id(input logic [6:0] id);
        logic r;
        case (id)
            ID_BRSL, ID_BRASL: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_ctrl_sat_counter.sv
// Saturating up-counter used for the branch performance statistics.
// The count sticks at all-ones once reached.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;
    logic             w_inc;

    // Increment only when enabled and not yet saturated.
    always_comb begin
        w_inc = 1'b0;
        if (en && (r_count != CNT_MAX)) begin
            w_inc = 1'b1;
        end else begin
            w_inc = 1'b0;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_inc) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: accepts the resolved branch in execute,
// issues a one-cycle redirect/flush (and link write for brsl/brasl), then
// squashes further branches for the flush cycle plus SHADOW refill cycles.
// Keeps saturating counts of accepted and accepted-taken branches.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int SHADOW = BC_SHADOW_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_stall,
    input  logic             br_valid,
    input  logic [6:0]       br_instr_id,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic [6:0]       br_rt_addr,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic             rt_wr_en,
    output logic [6:0]       rt_wr_addr,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    // Value loaded into the refill counter when leaving FLUSH; the last
    // REFILL cycle is the one in which the counter reads zero.
    localparam logic [BC_REFILL_W-1:0] REFILL_LOAD = BC_REFILL_W'(SHADOW - 1);
    localparam logic [BC_REFILL_W-1:0] REFILL_ONE  = BC_REFILL_W'(1);

    bc_state_e              r_state;
    logic [BC_REFILL_W-1:0] r_refill_cnt;
    logic                   r_redirect_valid;
    logic [PC_W-1:0]        r_redirect_pc;
    logic                   r_flush;
    logic                   r_rt_wr_en;
    logic [6:0]             r_rt_wr_addr;
    logic                   r_busy;

    logic w_is_branch;
    logic w_is_link;
    logic w_accept;
    logic w_take;

    // Decode the presented instruction and decide acceptance; a link branch
    // is always treated as taken so the link write never goes missing.
    always_comb begin
        w_is_branch = is_branch_id(br_instr_id);
        w_is_link   = is_link_id(br_instr_id);
        w_accept    = 1'b0;
        w_take      = 1'b0;
        if ((r_state == ST_IDLE) && br_valid && !pipe_stall && w_is_branch) begin
            w_accept = 1'b1;
            w_take   = br_taken | w_is_link;
        end else begin
            w_accept = 1'b0;
            w_take   = 1'b0;
        end
    end

    // Controller FSM with registered pulse outputs; pulses always drop after
    // one cycle, while state and refill counter freeze under pipe_stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_refill_cnt     <= {BC_REFILL_W{1'b0}};
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= {PC_W{1'b0}};
            r_flush          <= 1'b0;
            r_rt_wr_en       <= 1'b0;
            r_rt_wr_addr     <= 7'd0;
            r_busy           <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_rt_wr_en       <= 1'b0;
            if (!pipe_stall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_take) begin
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= br_target;
                            r_flush          <= 1'b1;
                            r_state          <= ST_FLUSH;
                            r_busy           <= 1'b1;
                            if (w_is_link) begin
                                r_rt_wr_en   <= 1'b1;
                                r_rt_wr_addr <= br_rt_addr;
                            end else begin
                                r_rt_wr_addr <= r_rt_wr_addr;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        r_state      <= ST_REFILL;
                        r_refill_cnt <= REFILL_LOAD;
                        r_busy       <= 1'b1;
                    end
                    ST_REFILL: begin
                        if (r_refill_cnt == {BC_REFILL_W{1'b0}}) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_refill_cnt <= r_refill_cnt - REFILL_ONE;
                            r_busy       <= 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_refill_cnt <= {BC_REFILL_W{1'b0}};
                        r_busy       <= 1'b0;
                    end
                endcase
            end else begin
                r_state      <= r_state;
                r_refill_cnt <= r_refill_cnt;
                r_busy       <= r_busy;
            end
        end
    end

    // Accepted-branch counter.
    sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_accept),
        .count (br_count)
    );

    // Accepted-taken-branch counter.
    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_take),
        .count (taken_count)
    );

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign rt_wr_en       = r_rt_wr_en;
    assign rt_wr_addr     = r_rt_wr_addr;
    assign busy           = r_busy;

endmodule
